// File: rtl/exe_stage.sv
// Execute stage for the in-order LoongArch32 pipeline.
// ALU, iterative divider, SRAM request and forwarding to decode.
module exe_stage #(
  parameter int DS_TO_ES_WD = 156,
  parameter int ES_TO_MS_WD = 80
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   ms_allowin,
  output logic                   es_allowin,
  input  logic                   ds_to_es_valid,
  input  logic [DS_TO_ES_WD-1:0] ds_to_es_bus,
  output logic                   es_to_ms_valid,
  output logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  output logic [4:0]             es_fwd_waddr,
  output logic [31:0]            es_fwd_result,
  output logic                   es_ld_block
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  logic                   es_valid;
  logic [DS_TO_ES_WD-1:0] es_bus_r;
  logic                   es_ready_go;

  logic [31:0] es_pc;
  logic [31:0] es_src1;
  logic [31:0] es_src2;
  logic [31:0] es_st_data;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic        es_mem_we;
  logic [1:0]  es_st_code;
  logic [2:0]  es_ld_code;
  logic [11:0] es_alu_op;
  logic [2:0]  es_div_op;

  assign {es_div_op, es_alu_op, es_ld_code, es_st_code,
          es_mem_we, es_res_from_mem, es_gr_we, es_dest,
          es_st_data, es_src2, es_src1, es_pc} = es_bus_r;

  assign es_allowin = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go && !clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (clear) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_bus_r <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      es_bus_r <= ds_to_es_bus;
    end
  end

  logic [31:0] alu_result;

  always_comb begin
    alu_result = '0;
    unique case (1'b1)
      es_alu_op[0]:  alu_result = es_src1 + es_src2;
      es_alu_op[1]:  alu_result = es_src1 - es_src2;
      es_alu_op[2]:  alu_result = {31'd0,
                       $signed(es_src1) < $signed(es_src2)};
      es_alu_op[3]:  alu_result = {31'd0, es_src1 < es_src2};
      es_alu_op[4]:  alu_result = es_src1 & es_src2;
      es_alu_op[5]:  alu_result = ~(es_src1 | es_src2);
      es_alu_op[6]:  alu_result = es_src1 | es_src2;
      es_alu_op[7]:  alu_result = es_src1 ^ es_src2;
      es_alu_op[8]:  alu_result = es_src1 << es_src2[4:0];
      es_alu_op[9]:  alu_result = es_src1 >> es_src2[4:0];
      es_alu_op[10]: alu_result = $unsigned(
                       $signed(es_src1) >>> es_src2[4:0]);
      es_alu_op[11]: alu_result = es_src2;
      default:       alu_result = '0;
    endcase
  end

  div_state_t  div_state;
  logic [5:0]  div_cnt;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] div_dsr;
  logic        div_sgn_q;
  logic        div_sgn_r;
  logic        div_mod;
  logic        div_zero;

  logic        op_signed;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;

  assign op_signed = !es_div_op[1];
  assign abs_src1 = (op_signed && es_src1[31]) ? -es_src1 : es_src1;
  assign abs_src2 = (op_signed && es_src2[31]) ? -es_src2 : es_src2;

  // Remainder and dividend shift as one pair; quotient bits enter at LSB.
  assign rem_sh  = {div_rem, div_quo[31]};
  assign rem_ge  = rem_sh >= {1'b0, div_dsr};
  assign rem_sub = rem_sh[31:0] - div_dsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= IDLE;
      div_cnt   <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dsr   <= '0;
      div_sgn_q <= 1'b0;
      div_sgn_r <= 1'b0;
      div_mod   <= 1'b0;
      div_zero  <= 1'b0;
    end else if (clear) begin
      div_state <= IDLE;
    end else begin
      unique case (div_state)
        IDLE: begin
          if (es_valid && es_div_op[2]) begin
            div_state <= RUN;
            div_cnt   <= '0;
            div_quo   <= abs_src1;
            div_rem   <= '0;
            div_dsr   <= abs_src2;
            div_sgn_q <= op_signed && (es_src1[31] ^ es_src2[31]);
            div_sgn_r <= op_signed && es_src1[31];
            div_mod   <= es_div_op[0];
            div_zero  <= es_src2 == 32'd0;
          end
        end
        RUN: begin
          div_quo <= {div_quo[30:0], rem_ge};
          div_rem <= rem_ge ? rem_sub : rem_sh[31:0];
          div_cnt <= div_cnt + 6'd1;
          if (div_cnt == 6'd31) begin
            div_state <= DONE;
          end
        end
        DONE: begin
          if (ms_allowin) begin
            div_state <= IDLE;
          end
        end
        default: div_state <= IDLE;
      endcase
    end
  end

  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] div_result;
  logic [31:0] es_result;

  // Divide by zero bypasses sign fixup: all-ones quotient, raw dividend.
  assign div_q = div_zero  ? 32'hFFFF_FFFF :
                 div_sgn_q ? -div_quo : div_quo;
  assign div_r = div_zero  ? es_src1 :
                 div_sgn_r ? -div_rem : div_rem;
  assign div_result = div_mod ? div_r : div_q;

  assign es_ready_go = es_div_op[2] ? (div_state == DONE) : 1'b1;
  assign es_result = es_div_op[2] ? div_result : alu_result;

  logic [1:0] es_ld_off;
  logic       ld_half;
  logic       ale_ld;
  logic       ale_st;
  logic       es_ale;

  assign es_ld_off = alu_result[1:0];
  assign ld_half = (es_ld_code == 3'b011) || (es_ld_code == 3'b100);
  assign ale_ld = es_res_from_mem &&
                  (((es_ld_code == 3'b000) && (es_ld_off != 2'b00)) ||
                   (ld_half && es_ld_off[0]));
  assign ale_st = es_mem_we &&
                  (((es_st_code == 2'b00) && (es_ld_off != 2'b00)) ||
                   ((es_st_code == 2'b10) && es_ld_off[0]));
  assign es_ale = ale_ld || ale_st;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = es_st_data;
    unique case (es_st_code)
      2'b01: begin
        st_strb  = 4'b0001 << es_ld_off;
        st_wdata = {4{es_st_data[7:0]}};
      end
      2'b10: begin
        st_strb  = es_ld_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{es_st_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = es_st_data;
      end
    endcase
  end

  assign data_sram_en = es_valid && es_ready_go && ms_allowin && !clear &&
                        (es_res_from_mem || es_mem_we) && !es_ale;
  assign data_sram_we = (data_sram_en && es_mem_we) ? st_strb : 4'b0000;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_wdata;

  assign es_fwd_waddr  = (es_valid && es_gr_we) ? es_dest : 5'd0;
  assign es_fwd_result = es_result;
  assign es_ld_block   = es_valid && es_res_from_mem;

  assign es_to_ms_bus = {es_ale, es_ld_off, es_ld_code, es_st_code,
                         es_mem_we, es_res_from_mem, es_gr_we,
                         es_dest, es_result, es_pc};

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage in-order LoongArch32 pipeline, between decode and `mem_stage`. It registers the decoded instruction and computes the result with the existing combinational `alu`. DIV/MOD operations run on an internal 32-iteration restoring divider. Load/store requests go to the data SRAM so read data returns while the instruction is in MEM. The stage also drives forwarding and load-use information back to decode.

## Interface
- `DS_TO_ES_WD`, default 156: decode→execute bus width.
- `ES_TO_MS_WD`, default 80: execute→memory bus width.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `clear`  in  1  pipeline flush (exception/ertn from writeback)
- `ms_allowin`  in  1  memory stage can accept
- `es_allowin`  out  1  this stage can accept
- `ds_to_es_valid`  in  1  decode holds a valid instruction
- `ds_to_es_bus`  in  DS_TO_ES_WD  fields, LSB first:
  - `pc[31:0]`, `src1[63:32]`, `src2[95:64]`, `st_data[127:96]`
  - `dest[132:128]`, `gr_we[133]`, `res_from_mem[134]`, `mem_we[135]`
  - `st_code[137:136]`, `ld_code[140:138]`, `alu_op[152:141]`
  - `div_op[155:153]`: 0xx none, 100 div.w, 101 mod.w, 110 div.wu, 111 mod.wu
- `es_to_ms_valid`  out  1  valid toward memory stage
- `es_to_ms_bus`  out  ES_TO_MS_WD  fields, LSB first:
  - `pc[31:0]`, `result[63:32]`, `dest[68:64]`, `gr_we[69]`, `res_from_mem[70]`
  - `mem_we[71]`, `st_code[73:72]`, `ld_code[76:74]`, `ld_off[78:77]`, `exec_ALE[79]`
- `data_sram_en`  out  1  request strobe
- `data_sram_we`  out  4  byte write enables
- `data_sram_addr`  out  32  byte address
- `data_sram_wdata`  out  32  store data
- `es_fwd_waddr`  out  5  destination for forwarding; 0 = none
- `es_fwd_result`  out  32  value being computed
- `es_ld_block`  out  1  a load occupies EX; decode must stall dependents

## Operation
- Stage registers:
  - `es_valid` loads `ds_to_es_valid` when `es_allowin`.
  - The bus register loads when `ds_to_es_valid && es_allowin`.
  - `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
  - `es_to_ms_valid = es_valid && es_ready_go && !clear`.
- Non-divide instructions: `es_ready_go = 1`, result = alu(`alu_op`, `src1`, `src2`).
- Divider FSM has states IDLE, RUN, DONE and a 6-bit counter.
  - IDLE→RUN when `es_valid && div_op[2] && !clear`. On that edge it latches |src1| and |src2| (raw values for unsigned ops), the signs, `div_op`, and sets counter = 0.
  - RUN performs one restoring iteration per cycle: shift the remainder/quotient pair left, trial-subtract the divisor, and set the quotient bit if the result is non-negative. After the 32nd iteration (counter = 31) the FSM goes RUN→DONE.
  - In DONE, `es_ready_go = 1`. DONE→IDLE when `ms_allowin` (instruction leaves). While `ms_allowin = 0` the FSM holds DONE and the result.
  - `es_ready_go = 0` for divide instructions in IDLE/RUN.
- Sign fixup for signed ops: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient 0xFFFFFFFF, remainder = src1 unchanged (no fixup), for both signed and unsigned.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `clear`: next edge `es_valid` ← 0 and FSM ← IDLE from any state. The in-flight division is discarded.
- Memory access:
  - addr = alu result; `ld_off` = addr[1:0].
  - ALE is raised when a word access (ld_code 000 / st_code 00) has addr[1:0] ≠ 0, or a half access (ld_code 011/100, st_code 10) has addr[0] ≠ 0. Only instructions with `res_from_mem` or `mem_we` can raise ALE.
  - `data_sram_en = es_valid && es_ready_go && ms_allowin && !clear && (res_from_mem || mem_we) && !ALE`.
  - `data_sram_we` = strobe when en && `mem_we`, else 0:
    - st.w (00): 1111
    - st.b (01): 0001 << addr[1:0]
    - st.h (10): addr[1] ? 1100 : 0011
  - `data_sram_wdata`: st.w full word; st.b byte replicated ×4; st.h half replicated ×2.
- Forwarding:
  - `es_fwd_waddr = (es_valid && gr_we) ? dest : 0`.
  - `es_fwd_result` = current result, which is valid only when `es_ready_go`. Decode must stall on a divide that is not ready.
  - `es_ld_block = es_valid && res_from_mem`.

## Timing
- Reset values:
  - `es_valid` = 0, bus register = 0, FSM = IDLE.
  - `es_allowin` = 1, `es_to_ms_valid` = 0, `data_sram_en` = 0, `data_sram_we` = 0.
  - `es_fwd_waddr` = 0, `es_ld_block` = 0.
- Non-divide instruction: one cycle in EX when `ms_allowin = 1`.
- Divide entering EX in cycle T:
  - RUN in T+1..T+32.
  - DONE in T+33: `es_ready_go` and `es_to_ms_valid` are high that cycle.
  - Occupancy is 34 cycles with no backpressure.
- SRAM request is issued in the same cycle the instruction transfers to MEM; read data is valid the following cycle.
- A simultaneous `clear` and transfer means the transfer is suppressed: no `es_to_ms_valid` and no SRAM request.
- `reset` mid-division returns to the reset state next edge.

## Test plan
- add.w 5+7, `ms_allowin` = 1 → `es_to_ms_valid` 1 cycle after entry, result 12, `data_sram_en` 0.
- div.w 0xFFFFFFF9 / 2 and mod.w same operands → `es_ready_go` at T+33; results 0xFFFFFFFD and 0xFFFFFFFF.
- div.wu 100/0 → 0xFFFFFFFF; mod.w 0x80000000/0xFFFFFFFF → 0.
- st.b addr 0x1003, data 0x000000AB → `data_sram_we` 1000, wdata 0xABABABAB, en 1. st.h addr 0x1001 → `exec_ALE` 1, `data_sram_en` 0.
- Divide in RUN, `clear` at T+10 → FSM IDLE and `es_valid` 0 at T+11. Next instruction accepted at T+11 with no `es_to_ms_valid` from the killed divide.
- Divide reaches DONE while `ms_allowin` = 0 for 5 cycles → result held stable, `es_allowin` 0. Transfer occurs in the cycle `ms_allowin` rises.
